alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
// - Shares one 4-bit ALU datapath (opcode {s3,s2,s1,s0}, flags z/v) among NREQ requesters.
// - Round-robin grant; one operation in flight; registered operands and opcode to the ALU.
// - Captures ALU result and flags into a single tagged response channel with valid/ready.
// - Sits between client sequencers and the combinational alu instance; contains no arithmetic itself.
// PARAMETERS
// - NREQ     2   number of requesters, 2..4
// - ALU_LAT  1   cycles operands are held stable before result capture, 1..7
// PORTS
// - clk          in   1          single clock, rising edge
// - rst          in   1          synchronous, active-high reset
// - req_valid    in   NREQ       per-requester operation valid
// - req_ready    out  NREQ       one-hot grant; asserted only in the accept cycle
// - req_op       in   NREQ*4     per-requester opcode {s3,s2,s1,s0}; slice i = [4i+3:4i]
// - req_a        in   NREQ*4     operand A per requester; bit3 = MSB (drives alu a0)
// - req_b        in   NREQ*4     operand B per requester; bit3 = MSB (drives alu b0)
// - alu_a        out  4          registered operand A to the ALU
// - alu_b        out  4          registered operand B to the ALU
// - alu_s        out  4          registered opcode to the ALU, {s3,s2,s1,s0}
// - alu_y        in   4          ALU result
// - alu_z        in   1          ALU zero flag
// - alu_v        in   1          ALU carry/overflow flag, meaningful for add ops only
// - rsp_valid    out  1          response valid
// - rsp_ready    in   1          response accept
// - rsp_id       out  $clog2(NREQ)  index of requester owning the response
// - rsp_y        out  4          captured result
// - rsp_z        out  1          captured zero flag
// - rsp_v        out  1          captured v flag
// - rsp_err      out  1          illegal opcode; rsp_y/z/v = 0
// BEHAVIOUR
// - Reset: state IDLE; req_ready=0; rsp_valid=0; rsp_id/y/z/v/err=0; alu_a/b/s=0; RR pointer=NREQ-1, so requester 0 wins first.
// - Reset mid-operation: the in-flight op is dropped; no response is produced; no requester is re-granted.
// - Legal opcodes: 0000 AND, 0001 XOR, 0010 OR, 0011 ~B, 0100 A+~B, 0101 A+B, 0110 A+~B+1, 0111 A+B+1, 1000 ASR.
// - Illegal opcodes: 1001..1111.
// - IDLE:
//   - If any req_valid, the RR winner is the first valid index after the pointer, wrapping.
//   - req_ready[winner]=1 combinationally in the same cycle.
//   - The accept cycle captures op, a, b and id; the pointer is set to the winner.
//   - Legal op -> EXEC: alu_a/b/s are loaded and the latency counter is cleared.
//   - Illegal op -> RESP with rsp_err=1; alu_* are left unchanged.
//   - No request -> stay in IDLE.
// - EXEC:
//   - alu_* are held stable; the counter increments each cycle.
//   - When the counter reaches ALU_LAT-1, capture alu_y, alu_z and alu_v into rsp_*, then go to RESP.
//   - rsp_v = alu_v; the ALU already gates v to add ops.
// - RESP:
//   - rsp_valid=1; rsp_* are stable until the handshake.
//   - rsp_valid & rsp_ready -> IDLE; rsp_valid deasserts on the next cycle.
//   - No grant is issued while in EXEC or RESP; req_ready=0.
// - Latency with ALU_LAT=1:
//   - Grant in cycle T -> rsp_valid in T+2.
//   - Illegal op: rsp_valid in T+1.
//   - Peak throughput is one op per 3 cycles.
// - Requesters hold req_op/a/b stable while req_valid=1 and not granted; deasserting before grant is allowed and loses no state.
// - NREQ=1 degenerates correctly: the pointer is constant and rsp_id=0.
// STRUCTURE
// - Package alu_arb_pkg:
//   - opcode localparams (OP_AND..OP_ASR)
//   - state enum {IDLE, EXEC, RESP}
//   - function is_legal_op(logic [3:0])
// - Sub-module rr_arbiter #(N): inputs req, ptr; outputs gnt (one-hot) and gnt_idx; purely combinational.
// - Top level holds: FSM, operand/opcode registers, latency counter, response registers.
// - Bench instantiates the real alu, wired to alu_* with bit3->a0 ... bit0->a3.
// TESTING
// - req0 op=0101 a=0101 b=1101 -> grant T; rsp_valid T+2; id=0 y=0010 z=0 v=1 err=0.
// - req0 op=0110 a=0011 b=0011 -> y=0000 z=1 v=0.
// - req0 op=1000 a=1010 -> y=1101 z=0 v=0.
// - req0 and req1 held valid, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence matches; 3-cycle spacing.
// - req1 op=1011 -> rsp_valid T+1; err=1 y=0; alu_s unchanged from its previous value.
// - rsp_ready=0 for 5 cycles in RESP -> rsp_* stable and req_ready=0 throughout.
// - rst pulsed during EXEC -> rsp_valid stays 0; all outputs at reset values; next grant goes to req0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, FSM states and
// the opcode legality check used at grant time.
package alu_arb_pkg;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_XOR    = 4'b0001;
  localparam logic [3:0] OP_OR     = 4'b0010;
  localparam logic [3:0] OP_NOTB   = 4'b0011;
  localparam logic [3:0] OP_ADD_NB = 4'b0100;
  localparam logic [3:0] OP_ADD    = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_ADD_C  = 4'b0111;
  localparam logic [3:0] OP_ASR    = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_XOR, OP_OR, OP_NOTB, OP_ADD_NB,
      OP_ADD, OP_SUB, OP_ADD_C, OP_ASR: is_legal_op = 1'b1;
      default:                          is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the winner is the first requesting index
// strictly after ptr, wrapping back to index 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [N-1:0] above_ptr;
  logic [N-1:0] hi_req;
  logic [N-1:0] cand;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign above_ptr[gi] = (gi > int'(ptr));
    end
  endgenerate

  // Requests above the pointer take priority; otherwise wrap to the full set.
  assign hi_req = req & above_ptr;
  assign cand   = (|hi_req) ? hi_req : req;
  assign gnt    = cand & (~cand + N'(1));

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = IW'(i);
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NREQ requesters: round-robin
// grant, registered operands, one op in flight, tagged valid/ready response.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ALU_LAT = 1,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*4-1:0] req_op,
  input  logic [NREQ*4-1:0] req_a,
  input  logic [NREQ*4-1:0] req_b,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  output logic [3:0]      alu_s,
  input  logic [3:0]      alu_y,
  input  logic            alu_z,
  input  logic            alu_v,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [3:0]      rsp_y,
  output logic            rsp_z,
  output logic            rsp_v,
  output logic            rsp_err
);

  localparam int CW = 3;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  ptr_reg;
  logic [CW-1:0]   cnt_reg;
  logic [3:0]      alu_a_reg, alu_b_reg, alu_s_reg;
  logic [IDW-1:0]  rsp_id_reg;
  logic [3:0]      rsp_y_reg;
  logic            rsp_z_reg, rsp_v_reg, rsp_err_reg;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [3:0]      op_arr [NREQ];
  logic [3:0]      a_arr  [NREQ];
  logic [3:0]      b_arr  [NREQ];
  logic [3:0]      sel_op, sel_a, sel_b;
  logic            accept, sel_legal, lat_done;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign op_arr[gi] = req_op[4*gi +: 4];
      assign a_arr[gi]  = req_a[4*gi +: 4];
      assign b_arr[gi]  = req_b[4*gi +: 4];
    end
  endgenerate

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel_op    = op_arr[gnt_idx];
  assign sel_a     = a_arr[gnt_idx];
  assign sel_b     = b_arr[gnt_idx];
  assign sel_legal = is_legal_op(sel_op);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    accept     = 1'b0;
    lat_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          req_ready  = gnt;
          accept     = 1'b1;
          state_next = sel_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (cnt_reg == CW'(ALU_LAT - 1)) begin
          lat_done   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg     <= IDW'(NREQ - 1);
      cnt_reg     <= '0;
      alu_a_reg   <= '0;
      alu_b_reg   <= '0;
      alu_s_reg   <= '0;
      rsp_id_reg  <= '0;
      rsp_y_reg   <= '0;
      rsp_z_reg   <= 1'b0;
      rsp_v_reg   <= 1'b0;
      rsp_err_reg <= 1'b0;
    end else begin
      if (accept) begin
        ptr_reg    <= gnt_idx;
        rsp_id_reg <= gnt_idx;
        if (sel_legal) begin
          alu_a_reg <= sel_a;
          alu_b_reg <= sel_b;
          alu_s_reg <= sel_op;
          cnt_reg   <= '0;
        end else begin
          // Illegal ops bypass the ALU; its operand registers keep the last op.
          rsp_y_reg   <= '0;
          rsp_z_reg   <= 1'b0;
          rsp_v_reg   <= 1'b0;
          rsp_err_reg <= 1'b1;
        end
      end
      if (state_reg == EXEC) cnt_reg <= cnt_reg + CW'(1);
      if (lat_done) begin
        rsp_y_reg   <= alu_y;
        rsp_z_reg   <= alu_z;
        rsp_v_reg   <= alu_v;
        rsp_err_reg <= 1'b0;
      end
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_s     = alu_s_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = rsp_id_reg;
  assign rsp_y     = rsp_y_reg;
  assign rsp_z     = rsp_z_reg;
  assign rsp_v     = rsp_v_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
